// File: rtl/lsf_pkg.sv
// Shared widths, record types and FSM encoding for the LSF peak selector.
// Optional runner-up tracking is enabled by defining LSF_SECOND_PEAK_EN.
package lsf_pkg;

  localparam int NTHETA         = 16;
  localparam int W_bin_number_a = 7;
  localparam int W_count        = 4;
  localparam int W_theta        = $clog2(NTHETA);
  localparam int MIN_COUNT      = 3;
  localparam int W_peak         = W_theta + W_bin_number_a + W_count;

  typedef struct packed {
    logic [W_bin_number_a-1:0] rbin;
    logic [W_count-1:0]        count;
  } lane_max_t;

  // Field order matches the {theta, rbin, count} layout of peak_TDATA.
  typedef struct packed {
    logic [W_theta-1:0]        theta;
    logic [W_bin_number_a-1:0] rbin;
    logic [W_count-1:0]        count;
  } peak_t;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_SCAN  = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

endpackage

// File: rtl/lsf_peak_compare.sv
// Combinational best-vs-candidate select; the candidate wins only on a strictly
// larger count so the incumbent (lower theta / earlier rbin) keeps ties.
module lsf_peak_compare
  import lsf_pkg::*;
(
  input  peak_t incumbent,
  input  peak_t candidate,
  output logic  take,
  output peak_t winner
);

  assign take   = (candidate.count > incumbent.count);
  assign winner = take ? candidate : incumbent;

endmodule

// File: rtl/lsf_peak_select.sv
// Collects per-lane local maxima during an event, then scans lanes one per cycle
// and presents the best peak on a valid/ready output. Define LSF_SECOND_PEAK_EN
// to also report the runner-up from a different theta lane.
module lsf_peak_select
  import lsf_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             hist_reset,
  input  logic [NTHETA*W_bin_number_a-1:0] lane_rbin,
  input  logic [NTHETA*W_count-1:0]        lane_count,
  input  logic [NTHETA-1:0]                lane_vld,
  input  logic                             event_end,
  output logic [W_peak-1:0]                peak_TDATA,
  output logic                             peak_TVALID,
  input  logic                             peak_TREADY,
  output logic                             peak_found,
`ifdef LSF_SECOND_PEAK_EN
  output logic [W_peak-1:0]                peak2_TDATA,
  output logic                             peak2_found,
`endif
  output logic                             busy
);

  state_e             state_q, state_d;
  logic [W_theta-1:0] k_q, k_d;
  lane_max_t          lane_q [NTHETA];
  lane_max_t          lane_d [NTHETA];
  peak_t              best_q, best_d;
  peak_t              cand;
  peak_t              best_win;
  logic               best_take;
  logic               out_fire;
  logic               flush;

  assign out_fire = (state_q == ST_OUT) && peak_TREADY;
  // Both an accepted result and an event abort start the next event from scratch.
  assign flush    = hist_reset || out_fire;
  assign cand     = {k_q, lane_q[k_q]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (hist_reset) begin
      state_d = ST_ACCUM;
    end else begin
      case (state_q)
        ST_ACCUM: if (event_end) state_d = ST_SCAN;
        ST_SCAN:  if (k_q == W_theta'(NTHETA - 1)) state_d = ST_OUT;
        ST_OUT:   if (peak_TREADY) state_d = ST_ACCUM;
        default:  state_d = ST_ACCUM;
      endcase
    end
  end

  always_comb begin
    peak_TVALID = (state_q == ST_OUT);
    peak_TDATA  = peak_TVALID ? best_q : '0;
    peak_found  = peak_TVALID && (best_q.count >= W_count'(MIN_COUNT));
    busy        = (state_q != ST_ACCUM);
  end

  always_comb begin
    k_d = '0;
    if ((state_q == ST_SCAN) && !hist_reset) begin
      k_d = k_q + W_theta'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < NTHETA; i++) begin
      lane_d[i] = lane_q[i];
      if (flush) begin
        lane_d[i] = '0;
      end else if ((state_q == ST_ACCUM) && lane_vld[i] &&
                   (lane_count[i*W_count +: W_count] > lane_q[i].count)) begin
        lane_d[i].rbin  = lane_rbin[i*W_bin_number_a +: W_bin_number_a];
        lane_d[i].count = lane_count[i*W_count +: W_count];
      end
    end
  end

  lsf_peak_compare u_best_cmp (
    .incumbent (best_q),
    .candidate (cand),
    .take      (best_take),
    .winner    (best_win)
  );

  always_comb begin
    best_d = best_q;
    if (flush) begin
      best_d = '0;
    end else if ((state_q == ST_SCAN) && best_take) begin
      best_d = best_win;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q    <= '0;
      best_q <= '0;
      for (int i = 0; i < NTHETA; i++) begin
        lane_q[i] <= '0;
      end
    end else begin
      k_q    <= k_d;
      best_q <= best_d;
      for (int i = 0; i < NTHETA; i++) begin
        lane_q[i] <= lane_d[i];
      end
    end
  end

`ifdef LSF_SECOND_PEAK_EN
  peak_t second_q, second_d;
  peak_t second_win;
  logic  second_take;

  lsf_peak_compare u_second_cmp (
    .incumbent (second_q),
    .candidate (cand),
    .take      (second_take),
    .winner    (second_win)
  );

  // A displaced best always comes from an earlier lane, so it becomes the runner-up.
  always_comb begin
    second_d = second_q;
    if (flush) begin
      second_d = '0;
    end else if (state_q == ST_SCAN) begin
      if (best_take) begin
        second_d = best_q;
      end else if (second_take) begin
        second_d = second_win;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      second_q <= '0;
    end else begin
      second_q <= second_d;
    end
  end

  always_comb begin
    peak2_TDATA = peak_TVALID ? second_q : '0;
    peak2_found = peak_TVALID && (second_q.count >= W_count'(MIN_COUNT));
  end
`endif

endmodule

// File: tb/tb_lsf_peak_select.sv
// Self-checking bench for lsf_peak_select: table vectors, hand sequences and
// randomized events against a per-lane maximum model (LSF_SECOND_PEAK_EN aware).
module tb_lsf_peak_select;
  import lsf_pkg::*;

  logic                             clk = 1'b0;
  logic                             rst_n;
  logic                             hist_reset;
  logic [NTHETA*W_bin_number_a-1:0] lane_rbin;
  logic [NTHETA*W_count-1:0]        lane_count;
  logic [NTHETA-1:0]                lane_vld;
  logic                             event_end;
  logic [W_peak-1:0]                peak_TDATA;
  logic                             peak_TVALID;
  logic                             peak_TREADY;
  logic                             peak_found;
`ifdef LSF_SECOND_PEAK_EN
  logic [W_peak-1:0]                peak2_TDATA;
  logic                             peak2_found;
`endif
  logic                             busy;

  int checks = 0;
  int errors = 0;
  int m_cnt  [NTHETA];
  int m_rbin [NTHETA];

  always #5 clk = ~clk;

  lsf_peak_select dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hist_reset  (hist_reset),
    .lane_rbin   (lane_rbin),
    .lane_count  (lane_count),
    .lane_vld    (lane_vld),
    .event_end   (event_end),
    .peak_TDATA  (peak_TDATA),
    .peak_TVALID (peak_TVALID),
    .peak_TREADY (peak_TREADY),
    .peak_found  (peak_found),
`ifdef LSF_SECOND_PEAK_EN
    .peak2_TDATA (peak2_TDATA),
    .peak2_found (peak2_found),
`endif
    .busy        (busy)
  );

  typedef struct {
    int n;
    int l0; int r0; int c0;
    int l1; int r1; int c1;
    int l2; int r2; int c2;
    int et; int er; int ec; int ef;
  } vec_t;

  function automatic vec_t mkVec(input int n,
                                 input int l0, input int r0, input int c0,
                                 input int l1, input int r1, input int c1,
                                 input int l2, input int r2, input int c2,
                                 input int et, input int er, input int ec, input int ef);
    vec_t v;
    v.n = n;
    v.l0 = l0; v.r0 = r0; v.c0 = c0;
    v.l1 = l1; v.r1 = r1; v.c1 = c1;
    v.l2 = l2; v.r2 = r2; v.c2 = c2;
    v.et = et; v.er = er; v.ec = ec; v.ef = ef;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < NTHETA; i++) begin
      m_cnt[i]  = 0;
      m_rbin[i] = 0;
    end
  endtask

  // Best = highest count, lowest theta on ties; runner-up = same rule over the other lanes.
  task automatic modelPeak(output int t, output int r, output int c,
                           output int t2, output int r2, output int c2);
    t = 0; r = 0; c = 0;
    for (int i = 0; i < NTHETA; i++) begin
      if (m_cnt[i] > c) begin
        t = i; r = m_rbin[i]; c = m_cnt[i];
      end
    end
    t2 = 0; r2 = 0; c2 = 0;
    for (int i = 0; i < NTHETA; i++) begin
      if (i != t && m_cnt[i] > c2) begin
        t2 = i; r2 = m_rbin[i]; c2 = m_cnt[i];
      end
    end
  endtask

  task automatic applyStimulus(input logic [NTHETA-1:0] vld,
                               input logic [NTHETA*W_bin_number_a-1:0] rbins,
                               input logic [NTHETA*W_count-1:0] cnts,
                               input logic ev, input logic accept);
    lane_vld   = vld;
    lane_rbin  = rbins;
    lane_count = cnts;
    event_end  = ev;
    if (accept) begin
      for (int i = 0; i < NTHETA; i++) begin
        if (vld[i] && int'(cnts[i*W_count +: W_count]) > m_cnt[i]) begin
          m_cnt[i]  = int'(cnts[i*W_count +: W_count]);
          m_rbin[i] = int'(rbins[i*W_bin_number_a +: W_bin_number_a]);
        end
      end
    end
    @(posedge clk);
    #1;
    lane_vld  = '0;
    event_end = 1'b0;
  endtask

  task automatic writeLane(input int lane, input int rbin, input int cnt, input logic accept);
    logic [NTHETA-1:0]                vld;
    logic [NTHETA*W_bin_number_a-1:0] rb;
    logic [NTHETA*W_count-1:0]        ct;
    vld = '0; rb = '0; ct = '0;
    vld[lane] = 1'b1;
    rb[lane*W_bin_number_a +: W_bin_number_a] = W_bin_number_a'(rbin);
    ct[lane*W_count +: W_count] = W_count'(cnt);
    applyStimulus(vld, rb, ct, 1'b0, accept);
  endtask

  task automatic endEvent(input string tag,
                          input logic [NTHETA-1:0] fvld,
                          input logic [NTHETA*W_bin_number_a-1:0] frb,
                          input logic [NTHETA*W_count-1:0] fcnt,
                          input int hold, input bit use_model,
                          input int et, input int er, input int ec, input int ef);
    int    n;
    int    xt, xr, xc, xf;
    int    mt, mr, mc, m2t, m2r, m2c;
    peak_t got;
    peak_t want;
    logic [NTHETA-1:0]                jvld;
    logic [NTHETA*W_bin_number_a-1:0] jrb;
    logic [NTHETA*W_count-1:0]        jct;
    peak_TREADY = (hold == 0);
    applyStimulus(fvld, frb, fcnt, 1'b1, 1'b1);
    n = 1;
    checkOutput({tag, "_busy_scan"}, 32'(busy), 32'd1);
    while (!peak_TVALID && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    modelPeak(mt, mr, mc, m2t, m2r, m2c);
    if (use_model) begin
      xt = mt; xr = mr; xc = mc; xf = (mc >= MIN_COUNT) ? 1 : 0;
    end else begin
      xt = et; xr = er; xc = ec; xf = ef;
    end
    checkOutput({tag, "_latency"}, 32'(n), 32'(NTHETA + 1));
    got = peak_TDATA;
    checkOutput({tag, "_theta"}, 32'(got.theta), 32'(xt));
    checkOutput({tag, "_rbin"}, 32'(got.rbin), 32'(xr));
    checkOutput({tag, "_count"}, 32'(got.count), 32'(xc));
    checkOutput({tag, "_found"}, 32'(peak_found), 32'(xf));
    checkOutput({tag, "_busy_out"}, 32'(busy), 32'd1);
`ifdef LSF_SECOND_PEAK_EN
    got = peak2_TDATA;
    checkOutput({tag, "_p2_theta"}, 32'(got.theta), 32'(m2t));
    checkOutput({tag, "_p2_rbin"}, 32'(got.rbin), 32'(m2r));
    checkOutput({tag, "_p2_count"}, 32'(got.count), 32'(m2c));
    checkOutput({tag, "_p2_found"}, 32'(peak2_found), (m2c >= MIN_COUNT) ? 32'd1 : 32'd0);
`endif
    want.theta = W_theta'(xt);
    want.rbin  = W_bin_number_a'(xr);
    want.count = W_count'(xc);
    jvld = '0; jrb = '0; jct = '0;
    jvld[8] = 1'b1;
    jrb[8*W_bin_number_a +: W_bin_number_a] = 7'd99;
    jct[8*W_count +: W_count] = 4'd9;
    for (int h = 0; h < hold; h++) begin
      applyStimulus(jvld, jrb, jct, 1'b1, 1'b0);
      checkOutput({tag, "_hold_valid"}, 32'(peak_TVALID), 32'd1);
      checkOutput({tag, "_hold_data"}, 32'(peak_TDATA), 32'(want));
    end
    peak_TREADY = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({tag, "_valid_drop"}, 32'(peak_TVALID), 32'd0);
    checkOutput({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs [7];
    logic [NTHETA-1:0]   rv;
    logic [127:0]        r128;
    logic [63:0]         c64;
    int                  seen;

    vecs[0] = mkVec(3, 3,10,2,   3,11,4,   3,12,5,   3,12,5,1);
    vecs[1] = mkVec(3, 2,20,6,   9,30,6,   5,1,2,    2,20,6,1);
    vecs[2] = mkVec(1, 5,7,2,    0,0,0,    0,0,0,    5,7,2,0);
    vecs[3] = mkVec(0, 0,0,0,    0,0,0,    0,0,0,    0,0,0,0);
    vecs[4] = mkVec(3, 7,40,3,   7,41,3,   0,5,1,    7,40,3,1);
    vecs[5] = mkVec(2, 15,127,15, 14,1,14, 0,0,0,    15,127,15,1);
    vecs[6] = mkVec(3, 1,33,7,   4,44,5,   6,66,5,   1,33,7,1);

    rst_n = 1'b0; hist_reset = 1'b0; event_end = 1'b0; peak_TREADY = 1'b1;
    lane_vld = '0; lane_rbin = '0; lane_count = '0;
    modelClear();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_tdata", 32'(peak_TDATA), 32'd0);
    checkOutput("reset_tvalid", 32'(peak_TVALID), 32'd0);
    checkOutput("reset_found", 32'(peak_found), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_reset_busy", 32'(busy), 32'd0);

    for (int v = 0; v < 7; v++) begin
      modelClear();
      for (int j = 0; j < vecs[v].n; j++) begin
        if (j == 0)      writeLane(vecs[v].l0, vecs[v].r0, vecs[v].c0, 1'b1);
        else if (j == 1) writeLane(vecs[v].l1, vecs[v].r1, vecs[v].c1, 1'b1);
        else             writeLane(vecs[v].l2, vecs[v].r2, vecs[v].c2, 1'b1);
      end
      endEvent($sformatf("vec%0d", v), '0, '0, '0, 0, 1'b0,
               vecs[v].et, vecs[v].er, vecs[v].ec, vecs[v].ef);
    end

    // Back-pressure in OUT, with lane 8 activity that must not leak into the next event.
    modelClear();
    writeLane(10, 77, 8, 1'b1);
    endEvent("stall", '0, '0, '0, 5, 1'b0, 10, 77, 8, 1);
    modelClear();
    endEvent("after_stall", '0, '0, '0, 0, 1'b0, 0, 0, 0, 0);

    // lane_vld on the event_end cycle is still captured.
    modelClear();
    writeLane(2, 8, 4, 1'b1);
    rv = '0; rv[11] = 1'b1;
    r128 = '0; r128[11*W_bin_number_a +: W_bin_number_a] = 7'd90;
    c64 = '0; c64[11*W_count +: W_count] = 4'd12;
    endEvent("vld_on_end", rv, r128[NTHETA*W_bin_number_a-1:0], c64, 0, 1'b0, 11, 90, 12, 1);

    // Abort mid-scan; the following event must not see the aborted data.
    modelClear();
    writeLane(4, 50, 9, 1'b0);
    event_end = 1'b1;
    @(posedge clk);
    #1;
    event_end = 1'b0;
    checkOutput("abort_busy_scan", 32'(busy), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    hist_reset = 1'b1;
    @(posedge clk);
    #1;
    hist_reset = 1'b0;
    checkOutput("abort_busy_clear", 32'(busy), 32'd0);
    checkOutput("abort_tvalid", 32'(peak_TVALID), 32'd0);
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (peak_TVALID) seen++;
    end
    checkOutput("abort_no_valid", 32'(seen), 32'd0);
    writeLane(9, 5, 14, 1'b0);
    hist_reset = 1'b1;
    @(posedge clk);
    #1;
    hist_reset = 1'b0;
    writeLane(6, 3, 2, 1'b1);
    endEvent("after_abort", '0, '0, '0, 0, 1'b0, 6, 3, 2, 0);

    for (int e = 0; e < 25; e++) begin
      int ncyc;
      modelClear();
      ncyc = $urandom_range(1, 12);
      for (int c = 0; c < ncyc; c++) begin
        rv   = NTHETA'($urandom() & $urandom());
        r128 = {$urandom(), $urandom(), $urandom(), $urandom()};
        c64  = {$urandom(), $urandom()};
        applyStimulus(rv, r128[NTHETA*W_bin_number_a-1:0], c64, 1'b0, 1'b1);
      end
      rv   = NTHETA'($urandom() & $urandom());
      r128 = {$urandom(), $urandom(), $urandom(), $urandom()};
      c64  = {$urandom(), $urandom()};
      endEvent($sformatf("rand%0d", e), rv, r128[NTHETA*W_bin_number_a-1:0], c64,
               int'($urandom_range(0, 3)), 1'b1, 0, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
